srio_target_rx_buf: RTL

- Responder-side buffer on the SRIO core's target port: accepts inbound NWRITE/SWRITE beats (target_wr/target_addr/target_din/target_bus_sel) into a local 64-bit RAM.
- Serves inbound NREAD beats (target_rd -> target_dout).
- Counts a frame of N words, then locks the buffer until the user logic acknowledges.
- Sits between srio_v5_6_top's target interface and the downstream data-processing logic.

---
 rtl/srio_pkg.sv | 10 +
 rtl/srio_tdp_ram_be.sv | 38 +++
 rtl/srio_target_rx_buf.sv | 92 +++++++++
 3 files changed

// File: rtl/srio_pkg.sv
// srio_pkg: shared widths, FSM encoding and helpers for the SRIO target buffer
package srio_pkg;
   localparam int SRIO_DW   = 64;
   localparam int SRIO_BE_W = 8;
   localparam int SRIO_AW   = 32;
   typedef enum logic {ST_FILL = 1'b0, ST_HOLD = 1'b1} rx_state_e;
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
endpackage

// File: rtl/srio_tdp_ram_be.sv
// srio_tdp_ram_be: dual-port RAM, port A byte-enable read-before-write, port B read-only
module srio_tdp_ram_be
   import srio_pkg::*;
#(
   parameter int AW = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en_a,
   input  logic                 we_a,
   input  logic [AW-1:0]        addr_a,
   input  logic [SRIO_DW-1:0]   din_a,
   input  logic [SRIO_BE_W-1:0] be_a,
   output logic [SRIO_DW-1:0]   dout_a,
   input  logic                 en_b,
   input  logic [AW-1:0]        addr_b,
   output logic [SRIO_DW-1:0]   dout_b
);
   logic [SRIO_DW-1:0] mem [2**AW];
   logic [SRIO_DW-1:0] dout_a_q, dout_b_q;
   // byte-lane writes on port A; storage is never reset so it maps to block RAM
   always_ff @(posedge clk) begin
      for (int i = 0; i < SRIO_BE_W; i++)
         if (we_a && be_a[i]) mem[addr_a][8*i +: 8] <= din_a[8*i +: 8];
   end
   // registered reads that see the contents from before any same-edge write
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_a_q <= '0;
         dout_b_q <= '0;
      end else begin
         if (en_a) dout_a_q <= mem[addr_a];
         if (en_b) dout_b_q <= mem[addr_b];
      end
   end
   assign dout_a = dout_a_q;
   assign dout_b = dout_b_q;
endmodule

// File: rtl/srio_target_rx_buf.sv
// srio_target_rx_buf: SRIO target-port receive buffer with frame counting and hold/ack
module srio_target_rx_buf
   import srio_pkg::*;
#(
   parameter int          DEPTH_LOG2 = 9,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic                  user_clk,
   input  logic                  user_rst,
   input  logic                  target_wr,
   input  logic                  target_rd,
   input  logic [SRIO_AW-1:0]    target_addr,
   input  logic [SRIO_DW-1:0]    target_din,
   input  logic [SRIO_BE_W-1:0]  target_bus_sel,
   output logic [SRIO_DW-1:0]    target_dout,
   input  logic [15:0]           frame_len_cfg,
   output logic                  frame_ready,
   input  logic                  frame_ack,
   output logic [15:0]           frame_cnt,
   input  logic                  user_rd_en,
   input  logic [DEPTH_LOG2-1:0] user_rd_addr,
   output logic [SRIO_DW-1:0]    user_rd_data,
   output logic                  addr_err,
   output logic [15:0]           ovf_cnt
);
   rx_state_e           state_q, state_d;
   logic [15:0]         word_cnt_q, word_cnt_d;
   logic [15:0]         frame_cnt_q, frame_cnt_d;
   logic [15:0]         ovf_cnt_q, ovf_cnt_d;
   logic                addr_err_q, rd_oow_q;
   logic [SRIO_AW-1:0]  off;
   logic                in_win, wr_fill, cnt_en, done;
   logic [DEPTH_LOG2-1:0] widx;
   logic [SRIO_DW-1:0]  ram_dout_a;
   assign off     = target_addr - BASE_ADDR;
   assign in_win  = off[SRIO_AW-1:DEPTH_LOG2+3] == '0;
   assign widx    = off[DEPTH_LOG2+2:3];
   assign wr_fill = target_wr && in_win && state_q == ST_FILL;
   assign cnt_en  = wr_fill && target_bus_sel != '0 && frame_len_cfg != '0;
   assign done    = cnt_en && (word_cnt_q + 16'd1) == frame_len_cfg;
   srio_tdp_ram_be #(.AW(DEPTH_LOG2)) u_ram (
      .clk    (user_clk),
      .rst    (user_rst),
      .en_a   (target_rd && in_win),
      .we_a   (wr_fill),
      .addr_a (widx),
      .din_a  (target_din),
      .be_a   (target_bus_sel),
      .dout_a (ram_dout_a),
      .en_b   (user_rd_en),
      .addr_b (user_rd_addr),
      .dout_b (user_rd_data)
   );
   // next state: fill until the frame length is reached, then hold and count dropped writes until ack
   always_comb begin
      state_d     = state_q;
      word_cnt_d  = word_cnt_q;
      frame_cnt_d = frame_cnt_q;
      ovf_cnt_d   = ovf_cnt_q;
      if (state_q == ST_FILL) begin
         state_d     = done ? ST_HOLD : ST_FILL;
         word_cnt_d  = done ? 16'd0 : (cnt_en ? word_cnt_q + 16'd1 : word_cnt_q);
         frame_cnt_d = done ? frame_cnt_q + 16'd1 : frame_cnt_q;
      end else begin
         ovf_cnt_d = (target_wr && in_win) ? sat_inc16(ovf_cnt_q) : ovf_cnt_q;
         state_d   = frame_ack ? ST_FILL : ST_HOLD;
      end
   end
   // state, counters, error pulse and the out-of-window read flag
   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         state_q     <= ST_FILL;
         word_cnt_q  <= '0;
         frame_cnt_q <= '0;
         ovf_cnt_q   <= '0;
         addr_err_q  <= 1'b0;
         rd_oow_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_cnt_q  <= word_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         ovf_cnt_q   <= ovf_cnt_d;
         addr_err_q  <= (target_wr || target_rd) && !in_win;
         if (target_rd) rd_oow_q <= !in_win;
      end
   end
   assign target_dout = rd_oow_q ? '0 : ram_dout_a;
   assign frame_ready = state_q == ST_HOLD;
   assign frame_cnt   = frame_cnt_q;
   assign ovf_cnt     = ovf_cnt_q;
   assign addr_err    = addr_err_q;
endmodule
